instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the PC and instruction width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the instruction buffer depth; it is a power of two and at least 2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-004 SHALL use one clock, clk; reset is synchronous and active-high, named reset.
REQ-005 SHALL have these ports:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- redirect_valid  in  1  branch/jump taken, flush and refetch
- redirect_pc  in  XLEN  new fetch address
- req_valid  out  1  fetch request to instruction memory
- req_addr  out  XLEN  fetch address
- req_ready  in  1  memory accepts request
- resp_valid  in  1  instruction returned; responses arrive in order, latency of 1 or more cycles
- resp_data  in  XLEN  returned instruction
- inst_valid  out  1  instruction available to decode
- inst_data  out  XLEN  instruction at buffer head
- inst_pc  out  XLEN  PC of inst_data
- inst_ready  in  1  decode consumes head

Function
REQ-006 SHALL hold fetch_pc, a DEPTH-entry {pc, instr} FIFO, an outstanding counter (requests accepted, responses not yet returned), a drop_cnt counter and a resp_pc register.
REQ-007 SHALL set req_valid = !redirect_valid && (occupancy + outstanding < DEPTH); req_addr = fetch_pc.
REQ-008 On a request handshake (req_valid && req_ready), SHALL set fetch_pc += 4 (mod 2^XLEN, wraps) and outstanding += 1.
REQ-009 SHALL hold req_addr stable while req_valid is high and req_ready is low.
REQ-010 On resp_valid with drop_cnt = 0, SHALL push {resp_pc, resp_data}, set resp_pc += 4 and outstanding -= 1.
REQ-011 On resp_valid with drop_cnt > 0, SHALL discard the response and decrement both drop_cnt and outstanding.
REQ-012 Push always succeeds, because the credit rule of REQ-007 guarantees FIFO space; overflow is impossible by construction.
REQ-013 SHALL drive inst_valid = (occupancy != 0), with inst_data/inst_pc from the FIFO head; pop on inst_valid && inst_ready.
REQ-014 SHALL allow push and pop in the same cycle, leaving occupancy unchanged; a push into an empty FIFO is visible on inst_valid the next cycle (resp-to-inst latency is 1 cycle).
REQ-015 On redirect_valid, in the same clock edge, SHALL:
- empty the FIFO (any pop that cycle is ignored)
- set fetch_pc and resp_pc to {redirect_pc[XLEN-1:2], 2'b00}
- set drop_cnt to the outstanding count remaining after that cycle's response (any response in the redirect cycle is discarded)
REQ-016 Consecutive redirects SHALL be honoured; the last one wins; drop_cnt is recomputed each time per REQ-015.
REQ-017 Outstanding and drop_cnt SHALL be $clog2(DEPTH)+1 bits wide; drop_cnt <= outstanding <= DEPTH always.
REQ-018 inst_pc SHALL always be 4-byte aligned; the next inst_pc equals the previous inst_pc + 4 unless a redirect occurs in between.

Reset
REQ-019 While reset is high: fetch_pc = resp_pc = RESET_PC, FIFO empty, outstanding = drop_cnt = 0, req_valid = 0, inst_valid = 0; reset overrides redirect_valid.
REQ-020 Reset asserted mid-operation SHALL abandon in-flight requests; the memory is reset in the same cycle, so no stale responses are expected afterwards.
REQ-021 req_valid MAY assert in the first cycle after reset deasserts.

Verification
REQ-022 Reset then steady fetch: req_ready=1, latency 1, inst_ready=1 -> req_addr 0x0, 0x4, 0x8...; inst_pc sequence 0x0, 0x4, 0x8 with no gaps after fill.
REQ-023 Backpressure: inst_ready=0 with DEPTH=4 -> exactly 4 requests issued, req_valid then stays 0; inst_ready=1 for 1 cycle -> exactly one new request.
REQ-024 Redirect with 2 outstanding (latency 3): redirect_pc=0x100 -> both stale responses dropped; the next inst_pc is 0x100, then 0x104.
REQ-025 Redirect in the same cycle as resp_valid and inst_ready with 3 entries -> FIFO empty next cycle, inst_valid=0, the response is not pushed, and no entry is lost or duplicated after refetch.
REQ-026 Unaligned redirect_pc=0x203 -> req_addr 0x200.
REQ-027 Wrap-around with RESET_PC=0xFFFF_FFF8 -> req_addr 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues sequential fetches under a credit limit, buffers
// returned instructions with their PCs, and flushes/refetches on redirect.
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            req_valid,
    output logic [XLEN-1:0] req_addr,
    input  logic            req_ready,
    input  logic            resp_valid,
    input  logic [XLEN-1:0] resp_data,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   drop_cnt;
    logic [CW:0]     credit_sum;
    logic [XLEN-1:0] redirect_base;
    logic            req_fire;
    logic            resp_drop;
    logic            push;
    logic            pop;

    // Credit rule: buffered plus in-flight never exceeds DEPTH, so a push always fits.
    assign credit_sum    = {1'b0, count} + {1'b0, outstanding};
    assign req_valid     = !reset && !redirect_valid && (credit_sum < (CW+1)'(DEPTH));
    assign req_addr      = fetch_pc;
    assign req_fire      = req_valid && req_ready;

    assign redirect_base = {redirect_pc[XLEN-1:2], 2'b00};
    assign resp_drop     = resp_valid && (drop_cnt != '0);
    assign push          = resp_valid && (drop_cnt == '0) && !redirect_valid;

    assign inst_valid    = (count != '0);
    assign inst_data     = instr_mem[rd_ptr];
    assign inst_pc       = pc_mem[rd_ptr];
    assign pop           = inst_valid && inst_ready && !redirect_valid;

    assign outstanding_next = outstanding + CW'(req_fire) - CW'(resp_valid);

    // A redirect flushes the buffer and marks every still-pending response as stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_base;
                resp_pc  <= redirect_base;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                drop_cnt <= outstanding_next;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (push) begin
                    wr_ptr  <= wr_ptr + AW'(1);
                    resp_pc <= resp_pc + XLEN'(4);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
                if (resp_drop) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= resp_pc;
            instr_mem[wr_ptr] <= resp_data;
        end
    end

endmodule
